demux_1to4_8b_buf: RTL and testbench
====================================

Name: demux_1to4_8b_buf

Overview:
- Registered 1-to-4 byte demultiplexer. It is the distribution counterpart to the ALU's 4:1 operand/result multiplexers.
- Takes one WIDTH-bit stream with valid/ready handshake and a 2-bit destination select.
- Steers each accepted word into one of four per-channel FIFOs.
- Each FIFO drains independently through its own valid/ready output port.
- Sits between the ALU result bus and four downstream consumers (register-file write ports, output latches).

Parameters:
- WIDTH, 8, data width of input and each output channel.
- DEPTH, 2, entries per channel FIFO. Must be a power of 2, at least 2.
- CNTW, 8, width of the optional per-channel statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination channel. 0 to 3 selects out_data0 to out_data3.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  FIFO of channel in_sel can accept.
- out_data0, out_data1, out_data2, out_data3  output  WIDTH each  head word of the channel FIFO.
- out_valid  output  4  bit i high when FIFO i is non-empty.
- out_ready  input  4  bit i: consumer i takes the head this cycle.
- stat_cnt  output  4*CNTW  only with DEMUX_1TO4_STATS_EN. Channel i occupies bits [i*CNTW +: CNTW].

Behaviour:
- Single clock. All state updates on the rising edge of clk.
- Reset: when rst_n is low at a rising edge, all of the following are cleared together:
  - all FIFO pointers and counts go to 0;
  - all FIFO storage goes to 0;
  - out_valid goes to 4'b0000, and every out_dataN reads 0;
  - stat_cnt goes to 0.
  - Reset mid-transfer discards all buffered words. No handshake completes in a reset cycle.
- in_ready is combinational: in_ready = (count[in_sel] != DEPTH). It depends only on in_sel and registered state, never on out_ready.
- Push: occurs when in_valid & in_ready at a clock edge.
  - in_data is written at the write pointer of FIFO in_sel.
  - in_sel is sampled only at that edge. It may change freely while in_valid is low.
- Pop: for each channel i, occurs when out_valid[i] & out_ready[i] at a clock edge. The read pointer of FIFO i advances.
- Latency: a word pushed at edge k appears on out_dataN with out_valid set after edge k, i.e. in cycle k+1. There is no same-cycle bypass.
- out_dataN is always the registered head entry: mem[rd_ptr]. It is stable while out_valid is high and out_ready is low.
- Ordering:
  - strict FIFO order within a channel;
  - no ordering relation between channels;
  - all four channels may pop in the same cycle.
- Simultaneous push and pop on the same channel:
  - if not full, both occur and the count is unchanged;
  - if full, the push is blocked (in_ready low) even though a pop frees space that cycle. This is a deliberate choice: no ready-through-pop path.
- Full channel: in_ready stays low while in_sel points at it. A different in_sel may make in_ready high in the same cycle, so the source may retarget.
- Empty channel: out_valid[i] is low, and out_ready[i] is ignored. No pointer moves, and there is no underflow.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- out_ready asserted with out_valid low has no effect.
- X on in_sel while in_valid is low must not corrupt state.

Optional Feature:
- Macro: DEMUX_1TO4_STATS_EN.
- Defined:
  - the stat_cnt port exists;
  - counter i increments by 1 on each push to channel i;
  - counters saturate at all-ones and do not wrap;
  - cleared only by reset.
- Not defined:
  - no stat_cnt port and no counter logic;
  - all other behaviour is identical.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles with in_valid=1 and in_sel=2. Then out_valid=0000, in_ready=1, all out_dataN=0, and no push occurs.
- Routing latency: push 8'hA5 to sel 1 at edge k, with out_ready=0000. Then out_valid=0010 and out_data1=A5 in cycle k+1; the other channels stay empty.
- Fill and backpressure: with DEPTH=2, push 8'h11 then 8'h22 to sel 3 while out_ready=0000.
  - in_ready=0 with in_sel=3, and in_ready=1 with in_sel=0;
  - raising out_ready[3] pops 11, then 22, in order, and out_valid[3] then drops.
- Full with pop: channel 0 full; in the same cycle assert out_ready[0]=1 and push 8'h33 to sel 0. The push is rejected (in_ready=0), the pop occurs, and the count goes to 1. 8'h33 is accepted on the next cycle.
- Parallel drain and wrap: push the sequence 00..0F round-robin across sel 0 to 3 with all out_ready=1. Each channel emits its 4 words in order, and pointers wrap correctly with no loss or duplication.
- Stats (DEMUX_1TO4_STATS_EN, CNTW=8): push 300 words to sel 2. stat_cnt[23:16] saturates at 8'hFF, and the other fields stay 0. Reset returns all fields to 0.

Source files
------------

// File: rtl/demux_1to4_8b_buf_if.sv
// Bundle of the demux input stream, the four output channels and, when
// DEMUX_1TO4_STATS_EN is defined, the per-channel push counters.
// The master modport is the source/consumer side; the slave modport is the demux.
interface demux_1to4_8b_buf_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
`ifdef DEMUX_1TO4_STATS_EN
    logic [4*CNTW-1:0] stat_cnt;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, stat_cnt
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, stat_cnt
    );
`else
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
    );
`endif
endinterface

// File: rtl/demux_1to4_8b_buf.sv
// Registered 1-to-4 demultiplexer: each accepted word is steered by in_sel
// into one of four DEPTH-entry FIFOs, each draining through its own
// valid/ready port. Optional macro DEMUX_1TO4_STATS_EN adds saturating
// per-channel push counters on stat_cnt.
// in_ready never looks at out_ready: a full channel refuses a push even in a
// cycle where it pops, which keeps the source-side timing path short.
module demux_1to4_8b_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1to4_8b_buf_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNTW < 1) begin : g_bad_param
        $error("demux_1to4_8b_buf: DEPTH must be a power of 2 >= 2 and CNTW >= 1");
    end

    logic [WIDTH-1:0] mem    [4][DEPTH];
    logic [PW-1:0]    wr_ptr [4];
    logic [PW-1:0]    rd_ptr [4];
    logic [CW-1:0]    count  [4];
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [3:0]       nempty;

    // Handshake decode: acceptance for the selected channel, pops for non-empty channels.
    always_comb begin
        push   = 4'b0000;
        pop    = 4'b0000;
        nempty = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            nempty[i] = (count[i] != '0);
            pop[i]    = nempty[i] & bus.out_ready[i];
            push[i]   = bus.in_valid & bus.in_ready & (bus.in_sel == 2'(i));
        end
    end

    assign bus.in_ready  = (count[bus.in_sel] != FULL);
    assign bus.out_valid = nempty;
    assign bus.out_data0 = mem[0][rd_ptr[0]];
    assign bus.out_data1 = mem[1][rd_ptr[1]];
    assign bus.out_data2 = mem[2][rd_ptr[2]];
    assign bus.out_data3 = mem[3][rd_ptr[3]];

    // FIFO storage, pointers and occupancy; reset clears everything including data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= bus.in_data;
                    wr_ptr[i]         <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

`ifdef DEMUX_1TO4_STATS_EN
    logic [CNTW-1:0] stat [4];

    // Per-channel push counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i] && (stat[i] != '1)) begin
                    stat[i] <= stat[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_stat
        assign bus.stat_cnt[g*CNTW +: CNTW] = stat[g];
    end
`endif

endmodule

// File: tb/tb_demux_1to4_8b_buf.sv
// Directed bench for demux_1to4_8b_buf (DEPTH=2, WIDTH=8, CNTW=8).
module tb_demux_1to4_8b_buf;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    demux_1to4_8b_buf_if #(.WIDTH(8), .CNTW(8)) bus ();

    demux_1to4_8b_buf #(.WIDTH(8), .DEPTH(2), .CNTW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] chan_data(input int ch);
        case (ch)
            0:       return bus.out_data0;
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    initial begin
        n_total       = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        bus.in_data   = 8'h77;
        bus.out_ready = 4'b0000;

        // Reset held with a pending push: nothing may be accepted.
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h1);
        check("rst_data0", 32'(bus.out_data0), 32'h0);
        check("rst_data1", 32'(bus.out_data1), 32'h0);
        check("rst_data2", 32'(bus.out_data2), 32'h0);
        check("rst_data3", 32'(bus.out_data3), 32'h0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        check("idle_out_valid", 32'(bus.out_valid), 32'h0);

        // Routing latency: one word to channel 1.
        bus.in_sel   = 2'd1;
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("route_out_valid", 32'(bus.out_valid), 32'h2);
        check("route_data1",     32'(bus.out_data1), 32'hA5);
        bus.out_ready = 4'b0010;
        tick();
        bus.out_ready = 4'b0000;
        check("route_drained", 32'(bus.out_valid), 32'h0);

        // Fill channel 3 and check backpressure / retargeting.
        bus.in_sel   = 2'd3;
        bus.in_data  = 8'h11;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data  = 8'h22;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("fill_ready_sel3", 32'(bus.in_ready),  32'h0);
        check("fill_out_valid",  32'(bus.out_valid), 32'h8);
        check("fill_head3",      32'(bus.out_data3), 32'h11);
        bus.in_sel = 2'd0;
        #1;
        check("fill_ready_sel0", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 4'b1000;
        tick();
        check("drain3_second", 32'(bus.out_data3), 32'h22);
        check("drain3_valid",  32'(bus.out_valid), 32'h8);
        tick();
        check("drain3_empty",  32'(bus.out_valid), 32'h0);
        bus.out_ready = 4'b0000;

        // Full channel 0 with a simultaneous pop: push must be refused.
        bus.in_sel   = 2'd0;
        bus.in_data  = 8'h44;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data  = 8'h55;
        tick();
        bus.in_data  = 8'h33;
        bus.out_ready = 4'b0001;
        #1;
        check("full_ready_with_pop", 32'(bus.in_ready), 32'h0);
        tick();
        bus.out_ready = 4'b0000;
        #1;
        check("full_pop_head",   32'(bus.out_data0), 32'h55);
        check("full_pop_ready",  32'(bus.in_ready),  32'h1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("full_retry_full", 32'(bus.in_ready),  32'h0);
        check("full_retry_head", 32'(bus.out_data0), 32'h55);
        bus.out_ready = 4'b0001;
        tick();
        check("full_drain_33",   32'(bus.out_data0), 32'h33);
        tick();
        check("full_drain_empty", 32'(bus.out_valid), 32'h0);

        // Round-robin 00..0F with every consumer ready; pointers wrap.
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            bus.in_sel   = 2'(k % 4);
            bus.in_data  = 8'(k);
            bus.in_valid = 1'b1;
            tick();
            check($sformatf("rr_valid_%0d", k), 32'(bus.out_valid), 32'(1) << (k % 4));
            check($sformatf("rr_data_%0d", k),  32'(chan_data(k % 4)), 32'(k));
        end
        bus.in_valid = 1'b0;
        tick();
        check("rr_all_empty", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 4'b0000;

`ifdef DEMUX_1TO4_STATS_EN
        // Saturating counters: 300 pushes to channel 2 while it drains.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("stat_after_rst", bus.stat_cnt, 32'h0);
        bus.out_ready = 4'b0100;
        bus.in_sel    = 2'd2;
        bus.in_data   = 8'h5A;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        check("stat_saturated", bus.stat_cnt, 32'h00FF_0000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("stat_cleared", bus.stat_cnt, 32'h0);
        bus.out_ready = 4'b0000;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
